counter_sequencer: RTL and testbench

//  Run controller for the 8-bit enable/T-flip-flop up-counter: drives its Enable and Reset pins to time

---
 rtl/counter_sequencer.sv | 158 +++++++++++++++
 tb/tb_counter_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Run controller for an 8-bit enable/T-flip-flop up-counter: launches, paces, pauses and aborts counting runs.
// Optional macro CNT_SEQ_PERIOD_CNT_EN adds a saturating PeriodCount output of Done pulses.
module counter_sequencer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic [WIDTH-1:0]      Limit,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Periodic,
    input  logic [WIDTH-1:0]      CounterValue,
    output logic                  CountEn,
    output logic                  CountClr,
    output logic                  Busy,
`ifdef CNT_SEQ_PERIOD_CNT_EN
    output logic [7:0]            PeriodCount,
`endif
    output logic                  Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t                state_q,     state_d;
    logic [WIDTH-1:0]      limit_q,     limit_d;
    logic [PRESCALE_W-1:0] presc_q,     presc_d;
    logic                  periodic_q,  periodic_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic                  done_q,      done_d;

    logic at_limit;
    logic presc_tick;
    logic launch;

    // Terminal compare uses the latched limit so host changes mid-run are invisible.
    assign at_limit   = (CounterValue == limit_q);
    assign presc_tick = (presc_cnt_q == presc_q);

    always_comb begin
        // NOTE: every _d takes its held value first, so no branch leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        limit_d     = limit_q;
        presc_d     = presc_q;
        periodic_d  = periodic_q;
        presc_cnt_d = presc_cnt_q;
        done_d      = 1'b0;
        launch      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!Stop && Start) begin
                    launch  = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                presc_cnt_d = '0;
                state_d     = Stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                // Terminal count outranks Stop so a run that has finished always reports Done.
                if (at_limit) begin
                    done_d  = 1'b1;
                    state_d = periodic_q ? S_CLEAR : S_DONE;
                end else begin
                    presc_cnt_d = presc_tick ? '0 : presc_cnt_q + 1'b1;
                    if (Stop) begin
                        state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (Stop) begin
                    state_d = S_IDLE;
                end else if (Start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (Stop) begin
                    state_d = S_IDLE;
                end else if (Start) begin
                    launch  = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            limit_d    = Limit;
            presc_d    = Prescale;
            periodic_d = Periodic;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            limit_q     <= '0;
            presc_q     <= '0;
            periodic_q  <= 1'b0;
            presc_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the same pre-edge values regardless of statement order.
            state_q     <= state_d;
            limit_q     <= limit_d;
            presc_q     <= presc_d;
            periodic_q  <= periodic_d;
            presc_cnt_q <= presc_cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef CNT_SEQ_PERIOD_CNT_EN
    logic [7:0] period_cnt_q, period_cnt_d;
    logic       launch_idle;

    // Only a fresh launch from IDLE restarts the tally; relaunching from DONE accumulates.
    assign launch_idle = (state_q == S_IDLE) && Start && !Stop;

    always_comb begin
        period_cnt_d = period_cnt_q;
        if (launch_idle) begin
            period_cnt_d = '0;
        end else if (done_d && (period_cnt_q != 8'd255)) begin
            period_cnt_d = period_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign PeriodCount = period_cnt_q;
`endif

    assign CountEn  = (state_q == S_RUN) && presc_tick && !at_limit;
    assign CountClr = (state_q == S_CLEAR);
    assign Busy     = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_PAUSE);
    assign Done     = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: per-cycle vector table through a scoreboard queue,
// plus hand-written periodic, relaunch and (with CNT_SEQ_PERIOD_CNT_EN) PeriodCount sequences.
module tb_counter_sequencer;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Stop;
    logic [7:0] Limit;
    logic [3:0] Prescale;
    logic       Periodic;
    logic [7:0] counter_value;
    logic       CountEn;
    logic       CountClr;
    logic       Busy;
    logic       Done;
`ifdef CNT_SEQ_PERIOD_CNT_EN
    logic [7:0] PeriodCount;
`endif

    int checks   = 0;
    int failures = 0;

    counter_sequencer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .Stop         (Stop),
        .Limit        (Limit),
        .Prescale     (Prescale),
        .Periodic     (Periodic),
        .CounterValue (counter_value),
        .CountEn      (CountEn),
        .CountClr     (CountClr),
        .Busy         (Busy),
`ifdef CNT_SEQ_PERIOD_CNT_EN
        .PeriodCount  (PeriodCount),
`endif
        .Done         (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // The driven counter: clear wins over enable, global Reset also clears it.
    always @(posedge Clock) begin
        if (Reset || CountClr) begin
            counter_value <= 8'd0;
        end else if (CountEn) begin
            counter_value <= counter_value + 8'd1;
        end
    end

    typedef struct {
        bit         rst;
        bit         start;
        bit         stop;
        logic [7:0] limit;
        logic [3:0] presc;
        bit         per;
        bit         en;
        bit         clr;
        bit         busy;
        bit         done;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(bit r, bit s, bit p, int lim, int pre, bit per,
                                bit en, bit clr, bit busy, bit dn, int cnt);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p;
        v.limit = lim[7:0]; v.presc = pre[3:0]; v.per = per;
        v.en = en; v.clr = clr; v.busy = busy; v.done = dn; v.cnt = cnt[7:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, record the expectation, compare mid-cycle.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(posedge Clock);
        #1;
        Reset = v.rst; Start = v.start; Stop = v.stop;
        Limit = v.limit; Prescale = v.presc; Periodic = v.per;
        sb.push_back(v);
        @(negedge Clock);
        e = sb.pop_front();
        check($sformatf("row%0d CountEn", idx),  {31'd0, CountEn},  {31'd0, e.en});
        check($sformatf("row%0d CountClr", idx), {31'd0, CountClr}, {31'd0, e.clr});
        check($sformatf("row%0d Busy", idx),     {31'd0, Busy},     {31'd0, e.busy});
        check($sformatf("row%0d Done", idx),     {31'd0, Done},     {31'd0, e.done});
        check($sformatf("row%0d CounterValue", idx), {24'd0, counter_value}, {24'd0, e.cnt});
    endtask

    task automatic cyc(input bit s, input bit p);
        @(posedge Clock);
        #1;
        Start = s;
        Stop  = p;
        @(negedge Clock);
    endtask

    initial begin
        int done_at[3];
        int n_done;

        Reset = 1'b1; Start = 1'b0; Stop = 1'b0;
        Limit = 8'd0; Prescale = 4'd0; Periodic = 1'b0;
        repeat (2) @(posedge Clock);

        //             rst s p lim pre per  en clr bsy dn cnt
        // One-shot, Limit=3, Prescale=0
        vecs.push_back(mk(1,0,0, 3,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,1,0, 3,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 3,0,0, 0,1,1,0,0));
        vecs.push_back(mk(0,0,0, 3,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,0,0, 3,0,0, 1,0,1,0,1));
        vecs.push_back(mk(0,0,0, 3,0,0, 1,0,1,0,2));
        vecs.push_back(mk(0,0,0, 3,0,0, 0,0,1,0,3));
        vecs.push_back(mk(0,0,0, 3,0,0, 0,0,0,1,3));
        vecs.push_back(mk(0,0,1, 3,0,0, 0,0,0,0,3));
        vecs.push_back(mk(0,0,0, 3,0,0, 0,0,0,0,3));
        // Limit=2, Prescale=2: enables in RUN cycles 3 and 6, terminal in RUN cycle 7
        vecs.push_back(mk(0,1,0, 2,2,0, 0,0,0,0,3));
        vecs.push_back(mk(0,0,0, 2,2,0, 0,1,1,0,3));
        vecs.push_back(mk(0,0,0, 2,2,0, 0,0,1,0,0));
        vecs.push_back(mk(0,0,0, 2,2,0, 0,0,1,0,0));
        vecs.push_back(mk(0,0,0, 2,2,0, 1,0,1,0,0));
        vecs.push_back(mk(0,0,0, 2,2,0, 0,0,1,0,1));
        vecs.push_back(mk(0,0,0, 2,2,0, 0,0,1,0,1));
        vecs.push_back(mk(0,0,0, 2,2,0, 1,0,1,0,1));
        vecs.push_back(mk(0,0,0, 2,2,0, 0,0,1,0,2));
        vecs.push_back(mk(0,0,1, 2,2,0, 0,0,0,1,2));
        vecs.push_back(mk(0,0,0, 2,2,0, 0,0,0,0,2));
        // Periodic, Limit=1: three periods of CLEAR+2 RUN; Stop at terminal still restarts
        vecs.push_back(mk(0,1,0, 1,0,1, 0,0,0,0,2));
        vecs.push_back(mk(0,0,0, 1,0,1, 0,1,1,0,2));
        vecs.push_back(mk(0,0,0, 1,0,1, 1,0,1,0,0));
        vecs.push_back(mk(0,0,0, 1,0,1, 0,0,1,0,1));
        vecs.push_back(mk(0,0,0, 1,0,1, 0,1,1,1,1));
        vecs.push_back(mk(0,0,0, 1,0,1, 1,0,1,0,0));
        vecs.push_back(mk(0,0,0, 1,0,1, 0,0,1,0,1));
        vecs.push_back(mk(0,0,0, 1,0,1, 0,1,1,1,1));
        vecs.push_back(mk(0,0,0, 1,0,1, 1,0,1,0,0));
        vecs.push_back(mk(0,0,1, 1,0,1, 0,0,1,0,1));
        vecs.push_back(mk(0,0,1, 1,0,1, 0,1,1,1,1));
        vecs.push_back(mk(0,0,0, 1,0,1, 0,0,0,0,0));
        // Pause at value 2 for 5 cycles, resume, finish at 5
        vecs.push_back(mk(0,1,0, 5,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 5,0,0, 0,1,1,0,0));
        vecs.push_back(mk(0,0,0, 5,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,0,1, 5,0,0, 1,0,1,0,1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0, 5,0,0, 0,0,1,0,2));
        vecs.push_back(mk(0,1,0, 5,0,0, 0,0,1,0,2));
        vecs.push_back(mk(0,1,0, 5,0,0, 1,0,1,0,2));
        vecs.push_back(mk(0,0,0, 5,0,0, 1,0,1,0,3));
        vecs.push_back(mk(0,0,0, 5,0,0, 1,0,1,0,4));
        vecs.push_back(mk(0,0,0, 5,0,0, 0,0,1,0,5));
        vecs.push_back(mk(0,0,1, 5,0,0, 0,0,0,1,5));
        vecs.push_back(mk(0,0,0, 5,0,0, 0,0,0,0,5));
        // Stop+Start together in PAUSE aborts with no Done
        vecs.push_back(mk(0,1,0, 5,0,0, 0,0,0,0,5));
        vecs.push_back(mk(0,0,0, 5,0,0, 0,1,1,0,5));
        vecs.push_back(mk(0,0,1, 5,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,1,1, 5,0,0, 0,0,1,0,1));
        vecs.push_back(mk(0,0,0, 5,0,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0, 5,0,0, 0,0,0,0,1));
        // Limit=0: no enables, Done right after the first RUN cycle
        vecs.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,1,1,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,1,0,0));
        vecs.push_back(mk(0,0,1, 0,0,0, 0,0,0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0));
        // Reset mid-RUN aborts at once, no Done
        vecs.push_back(mk(0,1,0, 4,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 4,0,0, 0,1,1,0,0));
        vecs.push_back(mk(0,0,0, 4,0,0, 1,0,1,0,0));
        vecs.push_back(mk(1,0,0, 4,0,0, 1,0,1,0,1));
        vecs.push_back(mk(0,0,0, 4,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0, 4,0,0, 0,0,0,0,0));
        // Limit/Start changes while busy ignored; relaunch from DONE latches fresh Limit=1
        vecs.push_back(mk(0,1,0, 2,0,0, 0,0,0,0,0));
        vecs.push_back(mk(0,1,0, 7,0,0, 0,1,1,0,0));
        vecs.push_back(mk(0,1,0, 7,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,1,0, 7,0,0, 1,0,1,0,1));
        vecs.push_back(mk(0,1,0, 7,0,0, 0,0,1,0,2));
        vecs.push_back(mk(0,1,0, 1,0,0, 0,0,0,1,2));
        vecs.push_back(mk(0,0,0, 7,0,0, 0,1,1,0,2));
        vecs.push_back(mk(0,0,0, 7,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,0,0, 7,0,0, 0,0,1,0,1));
        vecs.push_back(mk(0,0,1, 7,0,0, 0,0,0,1,1));
        vecs.push_back(mk(0,0,0, 7,0,0, 0,0,0,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Periodic Limit=2 Prescale=1: 5 RUN cycles per period, Done at 7, 13, 19 after Start
        Limit = 8'd2; Prescale = 4'd1; Periodic = 1'b1;
        done_at = '{-1, -1, -1};
        n_done  = 0;
        cyc(1'b1, 1'b0);
        for (int c = 1; c <= 60 && n_done < 3; c++) begin
            cyc(1'b0, 1'b0);
            if (Done === 1'b1) begin
                done_at[n_done] = c;
                n_done++;
                if (n_done == 3) begin
`ifdef CNT_SEQ_PERIOD_CNT_EN
                    check("period count after 3 periods", {24'd0, PeriodCount}, 32'd3);
`endif
                    Stop = 1'b1;
                end
            end
        end
        check("periodic done #1 cycle", done_at[0], 32'd7);
        check("periodic done #2 cycle", done_at[1], 32'd13);
        check("periodic done #3 cycle", done_at[2], 32'd19);
        cyc(1'b0, 1'b0);
        check("abort from CLEAR idle", {31'd0, Busy}, 32'd0);
`ifdef CNT_SEQ_PERIOD_CNT_EN
        check("period count held in IDLE", {24'd0, PeriodCount}, 32'd3);
`endif

        // One-shot Limit=0 from IDLE, then relaunch straight from DONE
        Limit = 8'd0; Prescale = 4'd0; Periodic = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        check("oneshot done", {31'd0, Done}, 32'd1);
`ifdef CNT_SEQ_PERIOD_CNT_EN
        check("period count cleared on idle launch", {24'd0, PeriodCount}, 32'd1);
`endif
        cyc(1'b0, 1'b0);
        check("relaunch from DONE clears counter", {31'd0, CountClr}, 32'd1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check("relaunch done", {31'd0, Done}, 32'd1);
`ifdef CNT_SEQ_PERIOD_CNT_EN
        check("period count kept on DONE launch", {24'd0, PeriodCount}, 32'd2);
`endif
        cyc(1'b0, 1'b0);
        check("stop from DONE idle", {31'd0, Busy}, 32'd0);

`ifdef CNT_SEQ_PERIOD_CNT_EN
        // Periodic Limit=0 gives a Done every 2 cycles; 600 cycles overflows 8 bits
        Periodic = 1'b1;
        cyc(1'b1, 1'b0);
        repeat (600) cyc(1'b0, 1'b0);
        check("period count saturates", {24'd0, PeriodCount}, 32'd255);
        check("still running after saturation", {31'd0, Busy}, 32'd1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check("stopped after saturation run", {31'd0, Busy}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
